// File: rtl/plab5_mcore_dma_checker_q_pkg.sv
// Shared definitions for the queued DMA security checker: response status
// codes, checker FSM states and the tag position inside the control field.
package plab5_mcore_dma_checker_q_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [1:0] STAT_OK      = 2'b00;
   localparam logic [1:0] STAT_DENY    = 2'b01;
   localparam logic [1:0] STAT_TIMEOUT = 2'b10;

   localparam int unsigned TAG_LSB = 36;

endpackage

// File: rtl/plab5_mcore_dma_req_fifo.sv
// Single-read single-write request FIFO; writes are dropped while full and
// reads are ignored while empty.
module plab5_mcore_dma_req_fifo #(
   parameter int unsigned p_width = 8,
   parameter int unsigned p_depth = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enq_val,
   input  logic [p_width-1:0] enq_data,
   input  logic               deq_val,
   output logic [p_width-1:0] deq_data,
   output logic               full,
   output logic               empty
);

   localparam int unsigned PTR_W = $clog2(p_depth);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [p_width-1:0] mem [p_depth];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_enq;
   logic               do_deq;

   assign do_enq   = enq_val && !full;
   assign do_deq   = deq_val && !empty;
   assign full     = (count == CNT_W'(p_depth));
   assign empty    = (count == '0);
   assign deq_data = mem[rd_ptr];

   // Pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_deq) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_enq && !do_deq)      count <= count + CNT_W'(1);
         else if (!do_enq && do_deq) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset && do_enq) mem[wr_ptr] <= enq_data;
   end

endmodule

// File: rtl/plab5_mcore_dma_checker_q.sv
// Queued security checker between the NoC and the DMA controller: buffers
// requests, admits those whose domain dominates the controller's, and reports.
module plab5_mcore_dma_checker_q
   import plab5_mcore_dma_checker_q_pkg::*;
#(
   parameter int unsigned p_addr_nbits = 32,
   parameter int unsigned p_ctrl_nbits = 47,
   parameter int unsigned p_tag_nbits  = 8,
   parameter int unsigned p_dom_nbits  = 2,
   parameter int unsigned p_depth      = 4,
   parameter int unsigned p_timeout    = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    noc_req_val,
   output logic                    noc_req_rdy,
   input  logic [p_dom_nbits-1:0]  noc_req_domain,
   input  logic [p_addr_nbits-1:0] noc_req_src_addr,
   input  logic [p_addr_nbits-1:0] noc_req_dest_addr,
   input  logic [p_ctrl_nbits-1:0] noc_req_control,
   output logic                    noc_resp_val,
   input  logic                    noc_resp_rdy,
   output logic [p_dom_nbits-1:0]  noc_resp_domain,
   output logic [p_tag_nbits-1:0]  noc_resp_tag,
   output logic [1:0]              noc_resp_status,
   output logic                    dma_val,
   input  logic                    dma_rdy,
   input  logic [p_dom_nbits-1:0]  dma_domain,
   output logic [p_addr_nbits-1:0] dma_src_addr,
   output logic [p_addr_nbits-1:0] dma_dest_addr,
   output logic [p_ctrl_nbits-1:0] dma_req_control,
   input  logic                    dma_ack
);

   localparam int unsigned ENTRY_W = p_dom_nbits + 2 * p_addr_nbits + p_ctrl_nbits;
   localparam int unsigned TIMER_W = $clog2(p_timeout + 1);

   state_t                  state;
   state_t                  state_next;
   logic [1:0]              status;
   logic [1:0]              status_next;
   logic [TIMER_W-1:0]      timer;
   logic [TIMER_W-1:0]      timer_next;
   logic                    pop;
   logic [p_dom_nbits-1:0]  w_dom;
   logic [p_addr_nbits-1:0] w_src;
   logic [p_addr_nbits-1:0] w_dest;
   logic [p_ctrl_nbits-1:0] w_ctrl;
   logic [ENTRY_W-1:0]      fifo_head;
   logic                    fifo_full;
   logic                    fifo_empty;

   plab5_mcore_dma_req_fifo #(
      .p_width (ENTRY_W),
      .p_depth (p_depth)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (noc_req_val),
      .enq_data ({noc_req_domain, noc_req_src_addr, noc_req_dest_addr, noc_req_control}),
      .deq_val  (pop),
      .deq_data (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Checker FSM next-state; ack wins over an expiring timer
   always_comb begin
      state_next  = state;
      status_next = status;
      timer_next  = timer;
      pop         = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_dom >= dma_domain) begin
               state_next = ST_REQ;
            end else begin
               status_next = STAT_DENY;
               state_next  = ST_RESP;
            end
         end
         ST_REQ: begin
            if (dma_rdy) begin
               timer_next = '0;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dma_ack) begin
               status_next = STAT_OK;
               state_next  = ST_RESP;
            end else if (timer == TIMER_W'(p_timeout - 1)) begin
               status_next = STAT_TIMEOUT;
               state_next  = ST_RESP;
            end else if (timer != '1) begin
               timer_next = timer + TIMER_W'(1);
            end
         end
         ST_RESP: begin
            if (noc_resp_rdy) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ST_IDLE;
         status <= STAT_OK;
         timer  <= '0;
         w_dom  <= '0;
         w_src  <= '0;
         w_dest <= '0;
         w_ctrl <= '0;
      end else begin
         state  <= state_next;
         status <= status_next;
         timer  <= timer_next;
         if (pop) {w_dom, w_src, w_dest, w_ctrl} <= fifo_head;
      end
   end

   // Data outputs are zeroed outside their active state so stale fields never leak
   assign noc_req_rdy     = !fifo_full;
   assign dma_val         = (state == ST_REQ);
   assign dma_src_addr    = dma_val ? w_src  : '0;
   assign dma_dest_addr   = dma_val ? w_dest : '0;
   assign dma_req_control = dma_val ? w_ctrl : '0;
   assign noc_resp_val    = (state == ST_RESP);
   assign noc_resp_domain = noc_resp_val ? w_dom : '0;
   assign noc_resp_tag    = noc_resp_val ? w_ctrl[TAG_LSB +: p_tag_nbits] : '0;
   assign noc_resp_status = noc_resp_val ? status : '0;

endmodule
